// File: rtl/redirect_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_defs (package)
// Brief   : Shared types for the front-end redirect controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_defs;

    typedef logic [31:0] u32_t;

    // Encoded so that a smaller value means an older, higher-priority source.
    typedef enum logic [1:0] {
        CM  = 2'd0,
        EX  = 2'd1,
        IF2 = 2'd2
    } redir_src_e;

    typedef struct packed {
        logic valid;
        u32_t pc;
    } redir_req_t;

    typedef struct packed {
        logic valid;
        u32_t pc;
        u32_t target;
        logic set;
    } btb_wr_t;

    localparam u32_t C_PC_RESET = 32'h0000_0000;

    function automatic logic src_outranks_or_equal(input redir_src_e a, input redir_src_e b);
        return (a <= b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btb_port_arb.sv
//------------------------------------------------------------------------------
// Module  : btb_port_arb
// Brief   : Single BTB write port shared by execute training and fetch2
//           invalidation, with a one-entry skid buffer for blocked invalidates.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btb_port_arb
    import cpu_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  redir_req_t upd,
    input  u32_t       upd_target,
    input  redir_req_t inv,
    input  logic       clear,
    output btb_wr_t    wr
);

    logic r_skid_v;
    u32_t r_skid_pc;
    logic w_skid_v_nxt;
    u32_t w_skid_pc_nxt;
    logic w_inv_ok;

    // An invalidate seen alongside a commit redirect is from a squashed path.
    assign w_inv_ok = inv.valid & ~clear;

    always_comb begin
        wr            = '0;
        w_skid_v_nxt  = r_skid_v;
        w_skid_pc_nxt = r_skid_pc;
        if (upd.valid) begin
            wr.valid  = 1'b1;
            wr.pc     = upd.pc;
            wr.target = upd_target;
            wr.set    = 1'b1;
            if (w_inv_ok) begin
                w_skid_v_nxt  = 1'b1;
                w_skid_pc_nxt = inv.pc;
            end
        end else if (r_skid_v && !clear) begin
            wr.valid     = 1'b1;
            wr.pc        = r_skid_pc;
            w_skid_v_nxt = w_inv_ok;
            if (w_inv_ok) begin
                w_skid_pc_nxt = inv.pc;
            end
        end else if (w_inv_ok) begin
            wr.valid = 1'b1;
            wr.pc    = inv.pc;
        end
        if (clear) begin
            w_skid_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_v  <= 1'b0;
            r_skid_pc <= C_PC_RESET;
        end else begin
            r_skid_v  <= w_skid_v_nxt;
            r_skid_pc <= w_skid_pc_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/redirect_ctrl.sv
//------------------------------------------------------------------------------
// Module  : redirect_ctrl
// Brief   : Arbitrates commit/execute/fetch2 redirects into fetch1 PC writes,
//           drives per-stage flushes and the shared BTB write port.
//           Optional macro REDIRECT_BYPASS_EN: same-cycle PC write from IDLE.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module redirect_ctrl
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cm_redir_valid,
    input  logic [31:0] cm_redir_pc,
    input  logic        ex_redir_valid,
    input  logic [31:0] ex_redir_pc,
    input  logic        if2_redir_valid,
    input  logic [31:0] if2_redir_pc,
    output logic        wr_pc_valid,
    output logic [31:0] wr_pc_pc,
    input  logic        wr_pc_ready,
    output logic        flush_if1,
    output logic        flush_if2,
    output logic        flush_id,
    output logic        flush_ex,
    input  logic        ex_btb_upd_valid,
    input  logic [31:0] ex_btb_upd_pc,
    input  logic [31:0] ex_btb_upd_target,
    input  logic        if2_btb_inv_valid,
    input  logic [31:0] if2_btb_inv_pc,
    output logic        btb_wr_valid,
    output logic [31:0] btb_wr_pc,
    output logic [31:0] btb_wr_target,
    output logic        btb_wr_set,
    output logic        busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    u32_t       r_pend_pc;
    redir_src_e r_pend_src;
    logic       r_rst_q;

    logic       w_blk;
    redir_req_t w_cm;
    redir_req_t w_ex;
    redir_req_t w_if2;
    redir_req_t w_upd;
    redir_req_t w_inv;
    logic       w_win_v;
    redir_src_e w_win_src;
    u32_t       w_win_pc;
    logic       w_accept;
    logic       w_byp;
    logic       w_pend;
    logic       w_wr_v;
    u32_t       w_wr_pc;
    btb_wr_t    w_btb;

    // Inputs are ignored during reset and the cycle after, so outputs stay quiet.
    assign w_blk = rst | r_rst_q;

    assign w_cm  = '{valid: cm_redir_valid  & ~w_blk, pc: cm_redir_pc};
    assign w_ex  = '{valid: ex_redir_valid  & ~w_blk, pc: ex_redir_pc};
    assign w_if2 = '{valid: if2_redir_valid & ~w_blk, pc: if2_redir_pc};
    assign w_upd = '{valid: ex_btb_upd_valid  & ~w_blk, pc: ex_btb_upd_pc};
    assign w_inv = '{valid: if2_btb_inv_valid & ~w_blk, pc: if2_btb_inv_pc};

    always_comb begin
        w_win_v   = 1'b1;
        w_win_src = CM;
        w_win_pc  = w_cm.pc;
        if (w_cm.valid) begin
            w_win_src = CM;
            w_win_pc  = w_cm.pc;
        end else if (w_ex.valid) begin
            w_win_src = EX;
            w_win_pc  = w_ex.pc;
        end else if (w_if2.valid) begin
            w_win_src = IF2;
            w_win_pc  = w_if2.pc;
        end else begin
            w_win_v = 1'b0;
        end
    end

    assign w_pend   = (r_state == S_PEND);
    // While pending, only a source at least as old as the pending one may replace it.
    assign w_accept = w_win_v & (~w_pend | src_outranks_or_equal(w_win_src, r_pend_src));

`ifdef REDIRECT_BYPASS_EN
    assign w_byp = ~w_pend & w_accept;
`else
    assign w_byp = 1'b0;
`endif

    assign w_wr_v  = w_pend | w_byp;
    assign w_wr_pc = w_pend ? r_pend_pc : w_win_pc;

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = (w_byp && wr_pc_ready) ? S_IDLE : S_PEND;
        end else if (w_pend && wr_pc_ready) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pend_pc  <= C_PC_RESET;
            r_pend_src <= CM;
            r_rst_q    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_rst_q <= 1'b0;
            if (w_accept) begin
                r_pend_pc  <= w_win_pc;
                r_pend_src <= w_win_src;
            end
        end
    end

    btb_port_arb u_btb_port_arb (
        .clk        (clk),
        .rst        (rst),
        .upd        (w_upd),
        .upd_target (ex_btb_upd_target),
        .inv        (w_inv),
        .clear      (w_cm.valid),
        .wr         (w_btb)
    );

    assign wr_pc_valid   = ~w_blk & w_wr_v;
    assign wr_pc_pc      = w_blk ? 32'h0 : w_wr_pc;
    assign flush_if1     = ~w_blk & (w_pend | w_accept);
    assign flush_if2     = ~w_blk & (w_pend | (w_accept & (w_win_src != IF2)));
    assign flush_id      = ~w_blk & w_accept & (w_win_src != IF2);
    assign flush_ex      = ~w_blk & w_accept & (w_win_src == CM);
    assign busy          = ~w_blk & w_pend;
    assign btb_wr_valid  = ~w_blk & w_btb.valid;
    assign btb_wr_pc     = w_blk ? 32'h0 : w_btb.pc;
    assign btb_wr_target = w_blk ? 32'h0 : w_btb.target;
    assign btb_wr_set    = ~w_blk & w_btb.set;

endmodule

`default_nettype wire

// File: tb/tb_redirect_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_redirect_ctrl
// Brief   : Directed scenarios plus random traffic against a reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cm_redir_valid, ex_redir_valid, if2_redir_valid;
    logic [31:0] cm_redir_pc, ex_redir_pc, if2_redir_pc;
    logic        wr_pc_valid, wr_pc_ready;
    logic [31:0] wr_pc_pc;
    logic        flush_if1, flush_if2, flush_id, flush_ex;
    logic        ex_btb_upd_valid, if2_btb_inv_valid;
    logic [31:0] ex_btb_upd_pc, ex_btb_upd_target, if2_btb_inv_pc;
    logic        btb_wr_valid, btb_wr_set, busy;
    logic [31:0] btb_wr_pc, btb_wr_target;

    redirect_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .cm_redir_valid    (cm_redir_valid),
        .cm_redir_pc       (cm_redir_pc),
        .ex_redir_valid    (ex_redir_valid),
        .ex_redir_pc       (ex_redir_pc),
        .if2_redir_valid   (if2_redir_valid),
        .if2_redir_pc      (if2_redir_pc),
        .wr_pc_valid       (wr_pc_valid),
        .wr_pc_pc          (wr_pc_pc),
        .wr_pc_ready       (wr_pc_ready),
        .flush_if1         (flush_if1),
        .flush_if2         (flush_if2),
        .flush_id          (flush_id),
        .flush_ex          (flush_ex),
        .ex_btb_upd_valid  (ex_btb_upd_valid),
        .ex_btb_upd_pc     (ex_btb_upd_pc),
        .ex_btb_upd_target (ex_btb_upd_target),
        .if2_btb_inv_valid (if2_btb_inv_valid),
        .if2_btb_inv_pc    (if2_btb_inv_pc),
        .btb_wr_valid      (btb_wr_valid),
        .btb_wr_pc         (btb_wr_pc),
        .btb_wr_target     (btb_wr_target),
        .btb_wr_set        (btb_wr_set),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: priority numbers 0=commit, 1=execute, 2=fetch2.
    bit          m_pend;
    logic [31:0] m_pc;
    int          m_src;
    bit          m_skid_v;
    logic [31:0] m_skid_pc;
    bit          m_rstq;

    task automatic clear_inputs();
        rst = 1'b0;
        cm_redir_valid = 1'b0;  cm_redir_pc  = '0;
        ex_redir_valid = 1'b0;  ex_redir_pc  = '0;
        if2_redir_valid = 1'b0; if2_redir_pc = '0;
        wr_pc_ready = 1'b0;
        ex_btb_upd_valid = 1'b0; ex_btb_upd_pc = '0; ex_btb_upd_target = '0;
        if2_btb_inv_valid = 1'b0; if2_btb_inv_pc = '0;
    endtask

    // Inputs are already applied (after a negedge); compare, clock, advance model.
    task automatic step();
        bit          blk, acc, byp, inv_ok, nsv;
        int          w;
        logic [31:0] wpc, nspc;
        bit          bv, bset;
        logic [31:0] bpc, btgt;
        #2;
        blk = rst || m_rstq;
        w = 3;
        wpc = '0;
        if (!blk) begin
            if (cm_redir_valid)       begin w = 0; wpc = cm_redir_pc;  end
            else if (ex_redir_valid)  begin w = 1; wpc = ex_redir_pc;  end
            else if (if2_redir_valid) begin w = 2; wpc = if2_redir_pc; end
        end
        acc = (w < 3) && (!m_pend || w <= m_src);
        byp = 1'b0;
`ifdef REDIRECT_BYPASS_EN
        byp = acc && !m_pend;
`endif
        nsv = m_skid_v; nspc = m_skid_pc;
        bv = 1'b0; bset = 1'b0; bpc = '0; btgt = '0;
        if (!blk) begin
            inv_ok = if2_btb_inv_valid && !cm_redir_valid;
            if (ex_btb_upd_valid) begin
                bv = 1'b1; bset = 1'b1; bpc = ex_btb_upd_pc; btgt = ex_btb_upd_target;
                if (inv_ok) begin nsv = 1'b1; nspc = if2_btb_inv_pc; end
            end else if (m_skid_v && !cm_redir_valid) begin
                bv = 1'b1; bpc = m_skid_pc;
                nsv = inv_ok;
                if (inv_ok) nspc = if2_btb_inv_pc;
            end else if (inv_ok) begin
                bv = 1'b1; bpc = if2_btb_inv_pc;
            end
            if (cm_redir_valid) nsv = 1'b0;
        end

        check_val("wr_pc_valid", wr_pc_valid, !blk && (m_pend || byp));
        if (blk)                   check_val("wr_pc_pc_rst", wr_pc_pc, 32'h0);
        else if (m_pend || byp)    check_val("wr_pc_pc", wr_pc_pc, m_pend ? m_pc : wpc);
        check_val("flush_if1", flush_if1, !blk && (m_pend || acc));
        check_val("flush_if2", flush_if2, !blk && (m_pend || (acc && w <= 1)));
        check_val("flush_id",  flush_id,  !blk && acc && w <= 1);
        check_val("flush_ex",  flush_ex,  !blk && acc && w == 0);
        check_val("busy",      busy,      !blk && m_pend);
        check_val("btb_valid", btb_wr_valid, bv);
        if (bv || blk) begin
            check_val("btb_pc",     btb_wr_pc, bpc);
            check_val("btb_target", btb_wr_target, btgt);
            check_val("btb_set",    btb_wr_set, bset);
        end

        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0; m_pc = '0; m_src = 0;
            m_skid_v = 1'b0; m_skid_pc = '0; m_rstq = 1'b1;
        end else if (m_rstq) begin
            m_rstq = 1'b0;
        end else begin
            if (acc) begin
                if (!(byp && wr_pc_ready)) begin
                    m_pend = 1'b1; m_pc = wpc; m_src = w;
                end
            end else if (m_pend && wr_pc_ready) begin
                m_pend = 1'b0;
            end
            m_skid_v = nsv; m_skid_pc = nspc;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        m_rstq = 1'b0; m_pend = 1'b0; m_pc = '0; m_src = 0;
        m_skid_v = 1'b0; m_skid_pc = '0;
        @(negedge clk);
        do_reset();
        check_val("reset_busy", busy, 1'b0);

        // Execute redirect from IDLE: flush now, PC write next cycle, idle after.
        ex_redir_valid = 1'b1; ex_redir_pc = 32'h1c000100; wr_pc_ready = 1'b1;
        #1 check_val("ex_flush_id_c0", flush_id, 1'b1);
        step();
        clear_inputs(); wr_pc_ready = 1'b1;
        #1 check_val("ex_wr_pc_c1", wr_pc_pc, 32'h1c000100);
        step();
        #1 check_val("ex_busy_c2", busy, 1'b0);
        step();

        // All three sources together: commit wins.
        do_reset();
        cm_redir_valid = 1'b1;  cm_redir_pc  = 32'h1c008000;
        ex_redir_valid = 1'b1;  ex_redir_pc  = 32'h1c000200;
        if2_redir_valid = 1'b1; if2_redir_pc = 32'h1c000304;
        #1 check_val("tri_flush_ex", flush_ex, 1'b1);
        step();
        clear_inputs(); wr_pc_ready = 1'b1;
        #1 check_val("tri_wr_pc", wr_pc_pc, 32'h1c008000);
        step();

        // Pending execute redirect: younger fetch2 dropped, commit replaces it.
        do_reset();
        ex_redir_valid = 1'b1; ex_redir_pc = 32'h1c000200;
        step();
        clear_inputs();
        repeat (3) step();
        if2_redir_valid = 1'b1; if2_redir_pc = 32'h1c000404;
        #1 check_val("pend_if2_drop", flush_id, 1'b0);
        step();
        clear_inputs();
        cm_redir_valid = 1'b1; cm_redir_pc = 32'h1c008000;
        step();
        clear_inputs(); wr_pc_ready = 1'b1;
        #1 check_val("pend_cm_pc", wr_pc_pc, 32'h1c008000);
        step();
        #1 check_val("pend_done", wr_pc_valid, 1'b0);
        step();

        // Concurrent BTB train and invalidate.
        do_reset();
        ex_btb_upd_valid = 1'b1; ex_btb_upd_pc = 32'h1c000010; ex_btb_upd_target = 32'h1c000800;
        if2_btb_inv_valid = 1'b1; if2_btb_inv_pc = 32'h1c000020;
        #1 check_val("btb_c0_set", btb_wr_set, 1'b1);
        step();
        clear_inputs();
        #1 check_val("btb_c1_pc", btb_wr_pc, 32'h1c000020);
        step();

        // Reset during a pending redirect abandons it.
        do_reset();
        ex_redir_valid = 1'b1; ex_redir_pc = 32'h1c000500;
        step();
        clear_inputs(); rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        #1 check_val("rst_pend_busy", busy, 1'b0);
        check_val("rst_pend_wr", wr_pc_valid, 1'b0);
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst               = ($urandom_range(0, 99) == 0);
            cm_redir_valid    = ($urandom_range(0, 15) == 0);
            ex_redir_valid    = ($urandom_range(0, 7) == 0);
            if2_redir_valid   = ($urandom_range(0, 5) == 0);
            cm_redir_pc       = $urandom & 32'hffff_fffc;
            ex_redir_pc       = $urandom & 32'hffff_fffc;
            if2_redir_pc      = $urandom & 32'hffff_fffc;
            wr_pc_ready       = $urandom_range(0, 1) == 1;
            ex_btb_upd_valid  = ($urandom_range(0, 3) == 0);
            ex_btb_upd_pc     = $urandom;
            ex_btb_upd_target = $urandom;
            if2_btb_inv_valid = ($urandom_range(0, 3) == 0);
            if2_btb_inv_pc    = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
